sample_decimator: RTL and testbench

//  Decimating acquisition stage directly downstream of the FIR low-pass filter in the MSO sample path.

---
 rtl/sample_decimator_pkg.sv | 25 ++
 rtl/sample_decimator_if.sv | 14 +
 rtl/sync_fifo_2w.sv | 72 +++++++
 rtl/sample_decimator.sv | 137 +++++++++++++
 tb/tb_sample_decimator.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sample_decimator_pkg.sv
// Shared types for the MSO decimation stage: mode encoding and peak word tags.
// The tag values are also decoded by the capture memory writer.
package sample_decimator_pkg;

  typedef enum logic [1:0] {
    ModeSample   = 2'd0,
    ModeAverage  = 2'd1,
    ModePeak     = 2'd2,
    ModeReserved = 2'd3
  } mode_e;

  localparam logic TagMin = 1'b0;
  localparam logic TagMax = 1'b1;

  // Reserved encoding falls back to plain sampling.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    m = mode_e'(raw);
    if (m == ModeReserved) begin
      m = ModeSample;
    end
    return m;
  endfunction

endpackage

// File: rtl/sample_decimator_if.sv
// Valid/ready result stream from the decimator to the capture memory writer.
interface sample_decimator_if #(
  parameter int unsigned DATA_WIDTH = 12
) ();

  logic                         valid;
  logic                         ready;
  logic signed [DATA_WIDTH-1:0] data;
  logic                         is_max;

  modport master (output valid, output data, output is_max, input ready);
  modport slave  (input valid, input data, input is_max, output ready);

endinterface

// File: rtl/sync_fifo_2w.sv
// First-word-fall-through FIFO taking 0, 1 or 2 writes plus one read per cycle.
// The head is registered so it holds its last value once the FIFO runs empty.
module sync_fifo_2w #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   wr_num,
  input  logic [WIDTH-1:0]             wr_data0,
  input  logic [WIDTH-1:0]             wr_data1,
  input  logic                         rd_en,
  output logic                         rd_valid,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   free
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             pop;

  assign pop = rd_en && (count_q != '0);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    if (wr_num != 2'd0) begin
      mem_d[wptr_q] = wr_data0;
      wptr_d        = wptr_q + PW'(1);
    end
    if (wr_num == 2'd2) begin
      mem_d[wptr_q + PW'(1)] = wr_data1;
      wptr_d                 = wptr_q + PW'(2);
    end
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q - CW'(pop) + CW'(wr_num);
    valid_d = (count_d != '0);
    head_d  = valid_d ? mem_d[rptr_d] : head_q;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = head_q;
  assign free     = CW'(DEPTH) - count_q;

endmodule

// File: rtl/sample_decimator.sv
// Decimates the FIR output stream by 2**log2 using sample, boxcar-average or min/max peak modes,
// buffering results in a small FIFO; results that do not fit are dropped and flagged sticky.
module sample_decimator
  import sample_decimator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned LOG2_MAX   = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        cfg_mode,
  input  logic [$clog2(LOG2_MAX+1)-1:0]     cfg_log2_ratio,
  input  logic                              in_valid,
  input  logic signed [DATA_WIDTH-1:0]      in_data,
  sample_decimator_if.master                out_if,
  output logic                              overrun,
  input  logic                              overrun_clr
);

  localparam int unsigned RW = $clog2(LOG2_MAX + 1);
  localparam int unsigned AW = DATA_WIDTH + LOG2_MAX;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  mode_e                        mode_q, cfg_mode_dec, mode_eff;
  logic [RW-1:0]                log2_q, cfg_log2_eff, log2_eff;
  logic [LOG2_MAX-1:0]          cnt_q, last_cnt;
  logic                         cnt_zero, is_last, frame_start;
  logic signed [AW-1:0]         acc_q, acc_sum, acc_shift, in_ext;
  logic signed [DATA_WIDTH-1:0] min_q, max_q, cur_min, cur_max;
  logic [1:0]                   wr_num, push_num;
  logic [DATA_WIDTH:0]          wr_data0, wr_data1, head;
  logic [CW-1:0]                free;
  logic [CW:0]                  avail;
  logic                         pop, fifo_valid, drop;

  assign cnt_zero    = (cnt_q == '0);
  assign frame_start = in_valid && cnt_zero;

  // Config from the ports applies to the sample that opens a frame; later samples use the shadow.
  always_comb begin
    cfg_mode_dec = decode_mode(cfg_mode);
    cfg_log2_eff = (cfg_log2_ratio > RW'(LOG2_MAX)) ? RW'(LOG2_MAX) : cfg_log2_ratio;
    if (cfg_mode_dec == ModePeak && cfg_log2_eff == '0) begin
      cfg_log2_eff = RW'(1);
    end
    mode_eff = cnt_zero ? cfg_mode_dec : mode_q;
    log2_eff = cnt_zero ? cfg_log2_eff : log2_q;
  end

  assign last_cnt = ~({LOG2_MAX{1'b1}} << log2_eff);
  assign is_last  = (cnt_q == last_cnt);

  assign in_ext    = {{LOG2_MAX{in_data[DATA_WIDTH-1]}}, in_data};
  assign acc_sum   = (cnt_zero ? '0 : acc_q) + in_ext;
  assign acc_shift = acc_sum >>> log2_eff;

  assign cur_min = (cnt_zero || in_data < min_q) ? in_data : min_q;
  assign cur_max = (cnt_zero || in_data > max_q) ? in_data : max_q;

  always_comb begin
    wr_num   = 2'd0;
    wr_data0 = {TagMin, in_data};
    wr_data1 = {TagMax, cur_max};
    if (in_valid) begin
      unique case (mode_eff)
        ModeAverage: begin
          if (is_last) begin
            wr_num   = 2'd1;
            wr_data0 = {TagMin, acc_shift[DATA_WIDTH-1:0]};
          end
        end
        ModePeak: begin
          if (is_last) begin
            wr_num   = 2'd2;
            wr_data0 = {TagMin, cur_min};
          end
        end
        default: begin
          if (cnt_zero) begin
            wr_num = 2'd1;
          end
        end
      endcase
    end
  end

  // A same-cycle pop frees its slot before the space check; a peak pair goes in whole or not at all.
  assign pop      = fifo_valid && out_if.ready;
  assign avail    = {1'b0, free} + (CW + 1)'(pop);
  assign drop     = (wr_num != 2'd0) && (avail < (CW + 1)'(wr_num));
  assign push_num = drop ? 2'd0 : wr_num;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= cfg_mode_dec;
      log2_q  <= cfg_log2_eff;
      cnt_q   <= '0;
      acc_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      overrun <= 1'b0;
    end else begin
      if (in_valid) begin
        cnt_q <= is_last ? '0 : cnt_q + LOG2_MAX'(1);
        acc_q <= acc_sum;
        min_q <= cur_min;
        max_q <= cur_max;
      end
      if (frame_start) begin
        mode_q <= cfg_mode_dec;
        log2_q <= cfg_log2_eff;
      end
      overrun <= drop | (overrun & ~overrun_clr);
    end
  end

  sync_fifo_2w #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_num   (push_num),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .rd_en    (pop),
    .rd_valid (fifo_valid),
    .rd_data  (head),
    .free     (free)
  );

  assign out_if.valid  = fifo_valid;
  assign out_if.data   = head[DATA_WIDTH-1:0];
  assign out_if.is_max = head[DATA_WIDTH];

endmodule

// File: tb/tb_sample_decimator.sv
// Directed bench for sample_decimator: stimulus pushes expected words, a negedge monitor pops them.
module tb_sample_decimator;

  localparam int DW = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           cfg_mode;
  logic [3:0]           cfg_log2_ratio;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 overrun;
  logic                 overrun_clr;

  sample_decimator_if #(.DATA_WIDTH(DW)) out_if ();

  sample_decimator #(
    .DATA_WIDTH (DW),
    .LOG2_MAX   (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_mode       (cfg_mode),
    .cfg_log2_ratio (cfg_log2_ratio),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_if         (out_if.master),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr)
  );

  always #5 clk = ~clk;

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  logic [DW:0]   exp_q[$];
  logic [DW:0]   mon_e;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_word(input int v, input logic tag);
    logic [DW-1:0] w;
    w = DW'(v);
    exp_q.push_back({tag, w});
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = DW'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_if.valid && out_if.ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got data %0d is_max %0d, expected no output",
                 out_if.data, out_if.is_max);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", longint'(out_if.data), longint'($signed(mon_e[DW-1:0])));
        check("out_is_max", longint'(out_if.is_max), longint'(mon_e[DW]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    cfg_mode       = 2'd0;
    cfg_log2_ratio = 4'd2;
    in_valid       = 1'b0;
    in_data        = '0;
    out_if.ready   = 1'b1;
    overrun_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", out_if.valid, 0);
    check("reset_data", out_if.data, 0);
    check("reset_is_max", out_if.is_max, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b0;

    // Sample mode, R=4, ramp
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) expect_word(i, 1'b0);
      send(i);
      if (i == 0) check("t1_latency_valid", out_if.valid, 1);
    end
    drain("t1_drain");
    check("t1_overrun", overrun, 0);

    // Average mode, R=4, floor rounding of negative sum
    cfg_mode = 2'd1;
    expect_word(-1, 1'b0);
    expect_word(5, 1'b0);
    send(1); send(2); send(3); send(-7);
    send(5); send(5); send(5); send(6);
    drain("t2_drain");

    // Peak mode, R=8
    cfg_mode       = 2'd2;
    cfg_log2_ratio = 4'd3;
    expect_word(-4, 1'b0);
    expect_word(9, 1'b1);
    send(3); send(-4); send(9); send(0); send(1); send(-2); send(7); send(2);
    drain("t3_drain");

    // Peak mode log2=0 runs as R=2; third pair overflows
    cfg_log2_ratio = 4'd0;
    out_if.ready   = 1'b0;
    expect_word(10, 1'b0);
    expect_word(20, 1'b1);
    expect_word(-5, 1'b0);
    expect_word(3, 1'b1);
    send(10); send(20); send(-5); send(3); send(7); send(8);
    check("t4_overrun_set", overrun, 1);
    check("t4_valid_full", out_if.valid, 1);
    repeat (2) @(posedge clk);
    #1;
    check("t4_head_stable", out_if.data, 10);
    overrun_clr = 1'b1;
    @(posedge clk);
    #1;
    overrun_clr = 1'b0;
    check("t4_overrun_clr", overrun, 0);
    out_if.ready = 1'b1;
    drain("t4_drain");

    // Mode change mid-frame: frame finishes as sample, next frame averages
    cfg_mode       = 2'd0;
    cfg_log2_ratio = 4'd2;
    expect_word(100, 1'b0);
    send(100); send(101);
    cfg_mode = 2'd1;
    send(102); send(103);
    expect_word(5, 1'b0);
    send(4); send(8); send(12); send(-4);
    drain("t5_drain");

    // Reset mid-frame with two buffered results
    out_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4);
    for (int i = 0; i < 4; i++) send(8);
    check("t6_valid_before", out_if.valid, 1);
    send(100); send(100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_valid_after_rst", out_if.valid, 0);
    check("t6_overrun_after_rst", overrun, 0);
    exp_q.delete();
    out_if.ready = 1'b1;
    expect_word(2, 1'b0);
    send(1); send(2); send(3); send(4);
    drain("t6_drain");

    // Average R=1 passes samples through
    cfg_log2_ratio = 4'd0;
    expect_word(-3, 1'b0);
    expect_word(7, 1'b0);
    expect_word(-2048, 1'b0);
    send(-3); send(7); send(-2048);
    drain("t7_drain");

    // Out-of-range ratio clamps to R=256: sum -64 >>> 8 = -1
    cfg_log2_ratio = 4'd15;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) expect_word(-1, 1'b0);
      send((i % 4 == 0) ? -7 : 2);
    end
    drain("t8_drain");
    check("final_overrun", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
